// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC frame scheduler and its round-robin arbiter.
package dac_pkg;

    localparam int NUM_REQ   = 4;
    localparam int SAMPLE_W  = 8;
    localparam int REQ_IDX_W = 2;

    localparam logic [SAMPLE_W-1:0] IDLE_CODE_DEFAULT = 8'h80;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [REQ_IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [REQ_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | REQ_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter; i_ptr is the previous winner, so the
// search begins at i_ptr+1 and the previous winner has lowest priority.
module rr_arbiter4
    import dac_pkg::*;
(
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [REQ_IDX_W-1:0] i_ptr,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic                 o_valid
);

    logic [REQ_IDX_W-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = i_ptr + REQ_IDX_W'(i);
            if (!o_valid && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_scheduler.sv
// Frame scheduler feeding one serial DAC from four sample requesters.
// Optional DAC_SCHED_UNDERRUN_CNT_EN adds a saturating underrun counter output.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | DAC disabled, fcnt held at 0; sched_en starts a frame
// ST_RUN  | DAC enabled, fcnt walks 0..FRAME_LEN-1 in step with serializer
module dac_scheduler
    import dac_pkg::*;
#(
    parameter int                  FRAME_LEN = 20,
    parameter logic [SAMPLE_W-1:0] IDLE_CODE = IDLE_CODE_DEFAULT
) (
    input  logic                         clk_DAC,
    input  logic                         rst,
    input  logic                         sched_en,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*SAMPLE_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         dac_en,
    output logic [SAMPLE_W-1:0]          dac_data,
    output logic [REQ_IDX_W-1:0]         grant_id,
    output logic                         frame_start,
    output logic                         busy
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                  underrun_cnt
`endif
);

    localparam logic [4:0] FCNT_LAST = 5'(FRAME_LEN - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [4:0]             r_fcnt;
    logic [4:0]             w_fcnt_nxt;
    logic [SAMPLE_W-1:0]    r_dac_data;
    logic [REQ_IDX_W-1:0]   r_grant_id;
    logic [REQ_IDX_W-1:0]   r_ptr;

    logic                   w_last;
    logic                   w_boundary;
    logic [NUM_REQ-1:0]     w_grant;
    logic                   w_arb_valid;
    logic [REQ_IDX_W-1:0]   w_grant_idx;
    logic [SAMPLE_W-1:0]    w_sample;

    rr_arbiter4 u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_valid (w_arb_valid)
    );

    assign w_last      = (r_fcnt == FCNT_LAST);
    assign w_grant_idx = onehot_to_idx(w_grant);

    always_comb begin
        w_sample = req_data[SAMPLE_W-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == REQ_IDX_W'(i)) begin
                w_sample = req_data[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // Boundary decisions are Mealy so the accept pulse lands in the load cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_boundary  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_fcnt_nxt = '0;
                if (sched_en) begin
                    w_boundary  = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_fcnt_nxt = '0;
                    if (sched_en) begin
                        w_boundary = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_fcnt_nxt = r_fcnt + 5'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_fcnt_nxt  = '0;
            end
        endcase
        if (rst) begin
            w_boundary = 1'b0;
        end
    end

    always_ff @(posedge clk_DAC) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fcnt     <= '0;
            r_dac_data <= IDLE_CODE;
            r_grant_id <= '0;
            r_ptr      <= REQ_IDX_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            if (w_boundary) begin
                if (w_arb_valid) begin
                    r_dac_data <= w_sample;
                    r_grant_id <= w_grant_idx;
                    r_ptr      <= w_grant_idx;
                end else begin
                    r_dac_data <= IDLE_CODE;
                end
            end
        end
    end

    assign req_ready   = w_boundary ? w_grant : '0;
    assign frame_start = w_boundary;
    assign dac_en      = (r_state == ST_RUN);
    assign busy        = dac_en;
    assign dac_data    = r_dac_data;
    assign grant_id    = r_grant_id;

`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;

    // The start load out of IDLE is not an underrun; only running frames count.
    always_ff @(posedge clk_DAC) begin
        if (rst) begin
            r_underrun_cnt <= '0;
        end else if (w_boundary && (r_state == ST_RUN) && !w_arb_valid
                     && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_dac_scheduler.sv
// Scoreboard bench for dac_scheduler: expected frame contents are queued as
// requester stimulus is applied and retired as frame_start pulses appear.
module tb_dac_scheduler;

    localparam int FRAME_LEN = 20;

    logic        clk_DAC = 1'b0;
    logic        rst;
    logic        sched_en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        dac_en;
    logic [7:0]  dac_data;
    logic [1:0]  grant_id;
    logic        frame_start;
    logic        busy;
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    dac_scheduler #(.FRAME_LEN(FRAME_LEN), .IDLE_CODE(8'h80)) dut (
        .clk_DAC     (clk_DAC),
        .rst         (rst),
        .sched_en    (sched_en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .dac_en      (dac_en),
        .dac_data    (dac_data),
        .grant_id    (grant_id),
        .frame_start (frame_start),
        .busy        (busy)
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 clk_DAC = ~clk_DAC;

    typedef struct {
        logic [3:0] ready;
        logic [7:0] sample;
        logic [1:0] gid;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int fs_seen = 0;
    int last_fs_cyc = 0;
    logic chk_pending = 1'b0;

    logic       ser_act = 1'b0;
    int         ser_slot = 0;
    logic [7:0] ser_sh = '0;

    logic [1:0] rr_last = 2'd3;
    logic [1:0] last_gid = 2'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_DAC);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] v, input logic [31:0] d);
        exp_t e;
        logic [1:0] idx;
        logic found;
        found = 1'b0;
        e.ready = 4'b0;
        e.sample = 8'h80;
        e.gid = last_gid;
        for (int i = 1; i <= 4; i++) begin
            idx = rr_last + 2'(i);
            if (!found && v[idx]) begin
                found = 1'b1;
                e.ready = 4'b0001 << idx;
                e.sample = d[idx*8 +: 8];
                e.gid = idx;
            end
        end
        if (found) begin
            rr_last = e.gid;
            last_gid = e.gid;
        end
        exp_q.push_back(e);
    endtask

    task automatic run_frames(input int n, input logic [3:0] v, input logic [31:0] d);
        int target;
        int budget;
        for (int k = 0; k < n; k++) push_exp(v, d);
        target = fs_seen + n;
        req_valid = v;
        req_data = d;
        sched_en = 1'b1;
        budget = n * FRAME_LEN + 10;
        while (fs_seen < target && budget > 0) begin
            step();
            budget--;
        end
        if (fs_seen < target) begin
            chk("fs_timeout", 32'(fs_seen), 32'(target));
            exp_q.delete();
        end
    endtask

    always @(posedge clk_DAC) cyc <= cyc + 1;

    always @(negedge clk_DAC) begin
        if (chk_pending) begin
            chk("dac_en_after_load", 32'(dac_en), 32'd1);
            chk("busy_after_load", 32'(busy), 32'd1);
            chk("dac_data", 32'(dac_data), 32'(cur.sample));
            chk("grant_id", 32'(grant_id), 32'(cur.gid));
            chk_pending = 1'b0;
        end
        if (rst) begin
            ser_act = 1'b0;
        end else if (ser_act) begin
            ser_slot++;
            if (ser_slot >= 1 && ser_slot <= 8) begin
                ser_sh = {ser_sh[6:0], dac_data[8 - ser_slot]};
                if (ser_slot == 8) chk("ser_byte", 32'(ser_sh), 32'(cur.sample));
            end
        end
        if (req_ready != 4'b0) chk("ready_masked", 32'(req_ready & ~req_valid), 32'd0);
        if (!frame_start) begin
            chk("ready_off_boundary", 32'(req_ready), 32'd0);
        end else begin
            if (exp_q.size() == 0) begin
                chk("fs_unexpected", 32'(frame_start), 32'd0);
            end else begin
                cur = exp_q.pop_front();
                chk("req_ready", 32'(req_ready), 32'(cur.ready));
                chk_pending = 1'b1;
                ser_act = 1'b1;
                ser_slot = -1;
            end
            if (dac_en) chk("fs_spacing", 32'(cyc - last_fs_cyc), 32'(FRAME_LEN));
            last_fs_cyc = cyc;
            fs_seen++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        sched_en = 1'b1;
        req_valid = 4'hF;
        req_data = 32'h11223344;
        repeat (3) step();
        chk("rst_dac_en", 32'(dac_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dac_data", 32'(dac_data), 32'h80);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
        chk("rst_underrun", 32'(underrun_cnt), 32'd0);
`endif
        sched_en = 1'b0;
        req_valid = 4'h0;
        step();
        rst = 1'b0;
        repeat (2) step();
        chk("idle_dac_en", 32'(dac_en), 32'd0);

        run_frames(1, 4'b0100, 32'h00A5_0000);
        run_frames(2, 4'hF, 32'hD4C3_B2A1);

        repeat (10) step();
        rst = 1'b1;
        sched_en = 1'b0;
        step();
        chk("midrst_dac_en", 32'(dac_en), 32'd0);
        chk("midrst_dac_data", 32'(dac_data), 32'h80);
        rr_last = 2'd3;
        last_gid = 2'd0;
        step();
        rst = 1'b0;
        step();

        run_frames(5, 4'hF, 32'h4433_2211);
        run_frames(3, 4'h0, 32'hFFFF_FFFF);
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
        chk("underrun_cnt", 32'(underrun_cnt), 32'd3);
`endif

        repeat (5) step();
        sched_en = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < FRAME_LEN - 5; i++) begin
            chk("drop_en_hold", 32'(dac_en), 32'd1);
            step();
        end
        chk("drop_en_low", 32'(dac_en), 32'd0);
        repeat (3) step();
        chk("drop_busy_low", 32'(busy), 32'd0);

        for (int f = 0; f < 50; f++) begin
            run_frames(1, 4'($urandom_range(0, 15)), $urandom);
        end
        sched_en = 1'b0;
        repeat (FRAME_LEN + 5) step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_dac_en", 32'(dac_en), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dac_scheduler.md
DAC_SCHEDULER -- requirements
Module: dac_scheduler

Interface
REQ-001 Parameter FRAME_LEN, default 20, SHALL be the serial-DAC frame length in clk_DAC cycles, range 10..31.
REQ-002 Parameter IDLE_CODE, default 8'h80, SHALL be the sample sent in a frame with no granted requester.
REQ-003 clk_DAC  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 sched_en  in  1  run request; high starts and continues framing.
REQ-006 req_valid  in  4  per-requester sample valid.
REQ-007 req_data  in  32  four 8-bit samples; requester i uses bits [8i+7:8i].
REQ-008 req_ready  out  4  one-hot, one-cycle accept pulse; sample taken when valid & ready.
REQ-009 dac_en  out  1  enable to the DAC serializer.
REQ-010 dac_data  out  8  sample to the serializer, stable for a whole frame.
REQ-011 grant_id  out  2  index of the requester owning the current frame.
REQ-012 frame_start  out  1  one-cycle pulse in the cycle a new frame's data is loaded.
REQ-013 busy  out  1  high whenever dac_en is high.

Function
REQ-014 States: IDLE and RUN; frame counter fcnt of 5 bits, 0..FRAME_LEN-1.
REQ-015 IDLE: dac_en=0, fcnt=0; sched_en=1 SHALL trigger a boundary load (REQ-017), next state RUN with dac_en=1 and fcnt=0 on the following cycle.
REQ-016 RUN: fcnt increments each cycle and wraps at FRAME_LEN-1; dac_en stays 1, tracking the serializer's internal counter exactly.
REQ-017 Boundary load, in IDLE with sched_en=1 or in RUN at fcnt==FRAME_LEN-1 with sched_en=1: round-robin arbitration, dac_data<=winner sample, req_ready[winner]=1 for that cycle, grant_id<=winner, frame_start=1.
REQ-018 Round-robin: search starts at last winner+1 mod 4; after reset, the last winner is 3, so requester 0 has top priority.
REQ-019 No valid requester at a boundary: dac_data<=IDLE_CODE, req_ready=0, grant_id and round-robin pointer unchanged, frame_start=1.
REQ-020 dac_data SHALL change only on a boundary load; req_valid/req_data changes mid-frame are ignored.
REQ-021 sched_en low at fcnt==FRAME_LEN-1: no load, next state IDLE, dac_en=0; sched_en falling mid-frame SHALL NOT truncate the frame.
REQ-022 req_ready is only ever asserted on a boundary cycle and never to a requester with req_valid=0.
REQ-023 Throughput: at most one sample per FRAME_LEN cycles; latency from accept to dac_data valid is 1 cycle.

Reset
REQ-024 rst=1: state IDLE, fcnt=0, dac_en=0, dac_data=IDLE_CODE, req_ready=0, grant_id=0, frame_start=0, busy=0, pointer=3; rst overrides all inputs.
REQ-025 rst mid-frame SHALL drop dac_en in the next cycle; the serializer SHALL be reset or re-aligned by the system whenever rst is applied mid-frame.

Configuration
REQ-026 DAC_SCHED_UNDERRUN_CNT_EN defined: adds output underrun_cnt (16 bits), which increments, saturating at 16'hFFFF, on every REQ-019 boundary in RUN, excluding the IDLE start load, and is cleared by rst.
REQ-027 DAC_SCHED_UNDERRUN_CNT_EN undefined: no underrun_cnt port or logic; all other behaviour is identical.

Structure
REQ-028 Shared package dac_pkg SHALL hold the state enum, the NUM_REQ=4 and SAMPLE_W=8 constants, and the IDLE_CODE default.
REQ-029 Sub-module rr_arbiter4 (4-bit request and pointer in, one-hot grant plus valid out, purely combinational) SHALL be instantiated once.

Verification
REQ-030 rst, then sched_en=1 with only req_valid[2]=1 and sample 8'hA5: the start cycle gives req_ready=4'b0100 and frame_start=1; next cycle dac_en=1 and dac_data=8'hA5.
REQ-031 All four requesters valid continuously: grant_id sequence 0,1,2,3,0 with frame_start spaced exactly 20 cycles apart.
REQ-032 No requesters valid while running: dac_data=8'h80 each frame, req_ready=0; with DAC_SCHED_UNDERRUN_CNT_EN, underrun_cnt=3 after 3 frames.
REQ-033 sched_en dropped at fcnt=5: dac_en stays 1 through fcnt=19, then goes 0; no further req_ready pulses occur.
REQ-034 rst asserted at fcnt=10: next cycle dac_en=0 and dac_data=8'h80; a restart then grants requester 0 first.
REQ-035 With a serializer model attached, serialized bits in frame slots 1..8 SHALL equal the granted sample, MSB first, for 50 random frames.
